// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared RV32I core types; fetch sequencing state of pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } pipe_fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/perf_counter.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter
// Description : Wrapping accumulator that adds a small increment every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter #(
    parameter int CNT_W = 32,
    parameter int INC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(inc);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Per-stage valid tracking and load-enable generation for the
//               RV32I pipeline: memory waits, load-use, redirects, fetch drain.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import rv32i_types::*;
#(
    parameter int NUM_STAGES     = 5,
    parameter int MEM_STAGE      = 3,
    parameter int REDIRECT_STAGE = 2,
    parameter int XLEN           = 32,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imem_resp,
    input  logic                  dmem_req,
    input  logic                  dmem_resp,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_is_load,
    input  logic [4:0]            ex_rd,
    input  logic                  redirect,
    input  logic [XLEN-1:0]       redirect_target,
    output logic [NUM_STAGES-1:0] stage_load,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic                  imem_read,
    output logic                  pc_sel_target,
    output logic [XLEN-1:0]       pc_target,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      squash_count
);

    localparam int C_INC_W = $clog2(NUM_STAGES) + 1;

    pipe_fetch_state_t     r_state;
    pipe_fetch_state_t     w_state_next;
    logic [NUM_STAGES-1:0] r_valid;
    logic [NUM_STAGES-1:0] w_valid_next;
    logic [NUM_STAGES-1:0] w_shift;
    logic [XLEN-1:0]       r_target;
    logic [C_INC_W-1:0]    w_squash_inc;
    logic [C_INC_W-1:0]    w_stall_inc;
    logic                  w_mem_wait;
    logic                  w_lu;
    logic                  w_rd;
    logic                  w_if_wait;

    assign w_mem_wait = r_valid[MEM_STAGE] & dmem_req & ~dmem_resp;
    assign w_lu       = r_valid[1] & r_valid[2] & ex_is_load & (ex_rd != 5'd0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign w_rd       = redirect & r_valid[REDIRECT_STAGE];
    assign w_if_wait  = ~imem_resp;
    assign w_shift    = {r_valid[NUM_STAGES-2:0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_valid  <= '0;
            r_target <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
            if (!w_mem_wait && w_rd) begin
                r_target <= redirect_target;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!w_mem_wait) begin
            if (w_rd) begin
                w_state_next = (r_state == FETCH && imem_resp) ? FETCH : DRAIN;
            end else if (r_state == DRAIN && imem_resp) begin
                w_state_next = FETCH;
            end
        end
    end

    always_comb begin
        stage_load    = '0;
        pc_sel_target = 1'b0;
        w_valid_next  = r_valid;
        w_squash_inc  = '0;
        // Both fetch states keep the request up; in DRAIN the PC is frozen.
        imem_read     = rst_n;
        pc_target     = (r_state == DRAIN && !w_rd) ? r_target : redirect_target;
        if (rst_n && !w_mem_wait) begin
            stage_load   = '1;
            w_valid_next = w_shift;
            if (w_rd) begin
                pc_sel_target = (r_state == FETCH) && imem_resp;
                stage_load[0] = pc_sel_target;
                for (int i = 1; i <= REDIRECT_STAGE; i++) begin
                    w_valid_next[i] = 1'b0;
                    w_squash_inc    = w_squash_inc + {{(C_INC_W-1){1'b0}}, r_valid[i]};
                end
            end else if (w_lu) begin
                stage_load[1:0] = 2'b00;
                w_valid_next[1] = r_valid[1];
                w_valid_next[2] = 1'b0;
            end else if (w_if_wait || r_state == DRAIN) begin
                // A word arriving in DRAIN is from the squashed path: drop it.
                stage_load[0]   = imem_resp;
                pc_sel_target   = (r_state == DRAIN) && imem_resp;
                w_valid_next[1] = 1'b0;
            end else begin
                w_valid_next[1] = 1'b1;
            end
        end
    end

    assign stage_valid = r_valid;
    assign w_stall_inc = {{(C_INC_W-1){1'b0}}, ~stage_load[0]};

    perf_counter #(
        .CNT_W (CNT_W),
        .INC_W (C_INC_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .count (stall_cycles)
    );

    perf_counter #(
        .CNT_W (CNT_W),
        .INC_W (C_INC_W)
    ) u_squash_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_squash_inc),
        .count (squash_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl (5 stages, MEM=3, redirect=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    typedef struct {
        logic        imr;
        logic        dreq;
        logic        dresp;
        int          hz;
        logic        rdr;
        logic [31:0] tgt;
        logic [4:0]  e_load;
        logic [4:0]  e_valid;
        logic        e_sel;
        logic [31:0] e_tgt;
        logic [31:0] e_stall;
        logic [31:0] e_squash;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_resp, dmem_req, dmem_resp;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_is_load;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [4:0]  stage_load, stage_valid;
    logic        imem_read, pc_sel_target;
    logic [31:0] pc_target, stall_cycles, squash_count;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [21];
    vec_t exp_q [$];

    always #5 clk = ~clk;

    pipe_ctrl #(
        .NUM_STAGES     (5),
        .MEM_STAGE      (3),
        .REDIRECT_STAGE (2),
        .XLEN           (32),
        .CNT_W          (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_resp       (imem_resp),
        .dmem_req        (dmem_req),
        .dmem_resp       (dmem_resp),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_is_load      (ex_is_load),
        .ex_rd           (ex_rd),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .stage_load      (stage_load),
        .stage_valid     (stage_valid),
        .imem_read       (imem_read),
        .pc_sel_target   (pc_sel_target),
        .pc_target       (pc_target),
        .stall_cycles    (stall_cycles),
        .squash_count    (squash_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic set_v(input int i, input logic imr, dreq, dresp, input int hz,
                         input logic rdr, input logic [31:0] tgt,
                         input logic [4:0] el, ev, input logic es,
                         input logic [31:0] et, est, esq);
        vecs[i] = '{imr, dreq, dresp, hz, rdr, tgt, el, ev, es, et, est, esq};
    endtask

    task automatic drive_defaults();
        imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_is_load = 1'b0; ex_rd = 5'd0; redirect = 1'b0; redirect_target = 32'h0;
    endtask

    task automatic apply(input vec_t v);
        drive_defaults();
        imem_resp = v.imr; dmem_req = v.dreq; dmem_resp = v.dresp;
        redirect = v.rdr; redirect_target = v.tgt;
        // hz 1: load to x5 with ID reading x5; hz 2: load to x0 with ID reading x0
        if (v.hz == 1) begin
            ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        end else if (v.hz == 2) begin
            ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        //      i  imr dq ds hz rd tgt       load      valid     sel tgt       stall squash
        set_v( 0, 1, 0, 0, 0, 0, 32'h0,   5'b11111, 5'b00000, 0, 32'h0,   0, 0);
        set_v( 1, 1, 0, 0, 0, 0, 32'h0,   5'b11111, 5'b00011, 0, 32'h0,   0, 0);
        set_v( 2, 1, 0, 0, 0, 0, 32'h0,   5'b11111, 5'b00111, 0, 32'h0,   0, 0);
        set_v( 3, 1, 0, 0, 0, 0, 32'h0,   5'b11111, 5'b01111, 0, 32'h0,   0, 0);
        set_v( 4, 1, 0, 0, 0, 0, 32'h0,   5'b11111, 5'b11111, 0, 32'h0,   0, 0);
        set_v( 5, 1, 0, 0, 1, 0, 32'h0,   5'b11100, 5'b11111, 0, 32'h0,   0, 0);
        set_v( 6, 1, 0, 0, 0, 0, 32'h0,   5'b11111, 5'b11011, 0, 32'h0,   1, 0);
        set_v( 7, 1, 0, 0, 2, 0, 32'h0,   5'b11111, 5'b10111, 0, 32'h0,   1, 0);
        set_v( 8, 1, 0, 0, 0, 0, 32'h0,   5'b11111, 5'b01111, 0, 32'h0,   1, 0);
        set_v( 9, 1, 1, 0, 0, 0, 32'h0,   5'b00000, 5'b11111, 0, 32'h0,   1, 0);
        set_v(10, 1, 1, 0, 0, 0, 32'h0,   5'b00000, 5'b11111, 0, 32'h0,   2, 0);
        set_v(11, 1, 1, 0, 0, 0, 32'h0,   5'b00000, 5'b11111, 0, 32'h0,   3, 0);
        set_v(12, 1, 1, 1, 0, 0, 32'h0,   5'b11111, 5'b11111, 0, 32'h0,   4, 0);
        set_v(13, 1, 0, 0, 0, 1, 32'h100, 5'b11111, 5'b11111, 1, 32'h100, 4, 0);
        set_v(14, 1, 0, 0, 0, 0, 32'h0,   5'b11111, 5'b11001, 0, 32'h0,   4, 2);
        set_v(15, 1, 0, 0, 0, 0, 32'h0,   5'b11111, 5'b10011, 0, 32'h0,   4, 2);
        set_v(16, 1, 0, 0, 0, 0, 32'h0,   5'b11111, 5'b00111, 0, 32'h0,   4, 2);
        set_v(17, 0, 0, 0, 0, 1, 32'h200, 5'b11110, 5'b01111, 0, 32'h200, 4, 2);
        set_v(18, 0, 0, 0, 0, 0, 32'h0,   5'b11110, 5'b11001, 0, 32'h200, 5, 4);
        set_v(19, 1, 0, 0, 0, 0, 32'h0,   5'b11111, 5'b10001, 1, 32'h200, 6, 4);
        set_v(20, 1, 0, 0, 0, 0, 32'h0,   5'b11111, 5'b00001, 0, 32'h0,   6, 4);

        rst_n = 1'b0;
        drive_defaults();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid",  32'(stage_valid),   32'h0);
        chk("reset_load",   32'(stage_load),    32'h0);
        chk("reset_imem",   32'(imem_read),     32'h0);
        chk("reset_stall",  stall_cycles,       32'h0);
        chk("reset_squash", squash_count,       32'h0);

        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) rst_n = 1'b1;
            apply(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("v%0d_load", i),   32'(stage_load),    32'(e.e_load));
            chk($sformatf("v%0d_valid", i),  32'(stage_valid),   32'(e.e_valid));
            chk($sformatf("v%0d_sel", i),    32'(pc_sel_target), 32'(e.e_sel));
            chk($sformatf("v%0d_tgt", i),    pc_target,          e.e_tgt);
            chk($sformatf("v%0d_imem", i),   32'(imem_read),     32'h1);
            chk($sformatf("v%0d_stall", i),  stall_cycles,       e.e_stall);
            chk($sformatf("v%0d_squash", i), squash_count,       e.e_squash);
        end

        // Fill to valid 01111, redirect without a response, then freeze in DRAIN.
        repeat (2) begin
            @(posedge clk); #1; drive_defaults();
        end
        @(posedge clk); #1;
        drive_defaults(); imem_resp = 1'b0; redirect = 1'b1; redirect_target = 32'h300;
        @(posedge clk); #1;
        drive_defaults(); imem_resp = 1'b0; dmem_req = 1'b1;
        @(negedge clk);
        chk("drain_valid",    32'(stage_valid), 32'h19);
        chk("drain_memwait",  32'(stage_load),  32'h0);
        chk("drain_tgt",      pc_target,        32'h300);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",  32'(stage_valid),   32'h0);
        chk("arst_load",   32'(stage_load),    32'h0);
        chk("arst_imem",   32'(imem_read),     32'h0);
        chk("arst_sel",    32'(pc_sel_target), 32'h0);
        chk("arst_stall",  stall_cycles,       32'h0);
        chk("arst_squash", squash_count,       32'h0);
        @(posedge clk); #1;
        drive_defaults(); redirect_target = 32'h55; rst_n = 1'b1;
        @(negedge clk);
        chk("restart_imem",  32'(imem_read),     32'h1);
        chk("restart_load",  32'(stage_load),    32'h1f);
        chk("restart_sel",   32'(pc_sel_target), 32'h0);
        chk("restart_tgt",   pc_target,          32'h55);
        @(posedge clk); #1;
        @(negedge clk);
        chk("restart_valid", 32'(stage_valid),   32'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
